// File: rtl/fifo_pkg.sv
// fifo_pkg: shared status type and sizing/threshold helpers for the FIFO controller
package fifo_pkg;
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
  function automatic int clamp_thresh(input int v, input int depth);
    return v > depth ? depth : v;
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-around pointer counter with synchronous reset and increment
module fifo_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/fifo_flag_ctrl.sv
// fifo_flag_ctrl: pointer, occupancy and status-flag controller for the synchronous FIFO
module fifo_flag_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int AF_DEFAULT = 10,
  parameter int AE_DEFAULT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              thresh_load,
  input  logic [ADDR_W:0]   af_thresh,
  input  logic [ADDR_W:0]   ae_thresh,
  input  logic              err_clr,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] w_ptr,
  output logic [ADDR_W-1:0] r_ptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);
  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_RST = (ADDR_W+1)'(clamp_thresh(AF_DEFAULT, DEPTH));
  localparam logic [ADDR_W:0] AE_RST = (ADDR_W+1)'(clamp_thresh(AE_DEFAULT, DEPTH));
  logic [ADDR_W:0] wp, rp, count_next, af_reg, ae_reg, af_new, ae_new;
  fifo_status_t st;
  assign wr_en = wr_req & ~st.full & ~rst;
  assign rd_en = rd_req & ~st.empty & ~rst;
  fifo_ptr #(.W(ADDR_W+1)) u_wptr (.clk(clk), .rst(rst), .inc(wr_en), .ptr(wp));
  fifo_ptr #(.W(ADDR_W+1)) u_rptr (.clk(clk), .rst(rst), .inc(rd_en), .ptr(rp));
  assign w_ptr = wp[ADDR_W-1:0];
  assign r_ptr = rp[ADDR_W-1:0];
  // The extra pointer MSB makes the difference span 0..DEPTH, so full and empty stay distinct
  assign count = wp - rp;
  always_comb begin
    count_next = (wr_en & ~rd_en) ? count + 1'b1 : (rd_en & ~wr_en) ? count - 1'b1 : count;
    af_new = (ADDR_W+1)'(clamp_thresh(int'(af_thresh), DEPTH));
    ae_new = (ADDR_W+1)'(clamp_thresh(int'(ae_thresh), DEPTH));
  end
  always_ff @(posedge clk)
    if (rst) begin
      st     <= '{full: 1'b0, empty: 1'b1, almost_full: (AF_RST == '0), almost_empty: 1'b1,
                  overflow: 1'b0, underflow: 1'b0};
      af_reg <= AF_RST;
      ae_reg <= AE_RST;
    end else begin
      st.full         <= count_next == DEPTH_V;
      st.empty        <= count_next == '0;
      st.almost_full  <= count_next >= af_reg;
      st.almost_empty <= count_next <= ae_reg;
      st.overflow     <= (wr_req & st.full) | (st.overflow & ~err_clr);
      st.underflow    <= (rd_req & st.empty) | (st.underflow & ~err_clr);
      if (thresh_load) begin
        af_reg <= af_new;
        ae_reg <= ae_new;
      end
    end
  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign overflow     = st.overflow;
  assign underflow    = st.underflow;
endmodule

// File: tb/tb_fifo_flag_ctrl.sv
// tb_fifo_flag_ctrl: table-driven phases with a per-cycle scoreboard of expected controller state
module tb_fifo_flag_ctrl;
  logic clk = 1'b0, rst = 1'b0, wr_req = 1'b0, rd_req = 1'b0, thresh_load = 1'b0, err_clr = 1'b0;
  logic [4:0] af_thresh = '0, ae_thresh = '0;
  logic wr_en, rd_en, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] w_ptr, r_ptr;
  logic [4:0] count;
  fifo_flag_ctrl #(.ADDR_W(4), .AF_DEFAULT(10), .AE_DEFAULT(2)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .thresh_load(thresh_load),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr), .wr_en(wr_en), .rd_en(rd_en),
    .w_ptr(w_ptr), .r_ptr(r_ptr), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [4:0] cnt;
    logic [3:0] wp, rp;
    logic full, empty, af, ae, ov, un;
  } snap_t;
  typedef struct packed {
    int wr, rd, tl, clr, r, af, ae, reps;
    int cnt, full, empty, afl, ael, ov, un;
  } vec_t;
  snap_t q[$];
  int checks = 0, failures = 0;
  int m_cnt = 0, m_wp = 0, m_rp = 0, m_af = 10, m_ae = 2, m_ov = 0, m_un = 0;
  task automatic step(input int wr, rd, tl, clr, r, af, ae);
    bit we, re;
    snap_t e, a;
    @(negedge clk);
    wr_req = wr[0]; rd_req = rd[0]; thresh_load = tl[0]; err_clr = clr[0]; rst = r[0];
    af_thresh = af[4:0]; ae_thresh = ae[4:0];
    we = (r == 0) && (wr != 0) && (m_cnt != 16);
    re = (r == 0) && (rd != 0) && (m_cnt != 0);
    #1;
    checks++;
    if ({wr_en, rd_en} !== {we, re}) begin
      failures++;
      $display("FAIL strobes: got wr_en/rd_en=%b%b want %b%b (count %0d)", wr_en, rd_en, we, re, m_cnt);
    end
    if (r != 0) begin
      m_cnt = 0; m_wp = 0; m_rp = 0; m_af = 10; m_ae = 2; m_ov = 0; m_un = 0;
    end else begin
      m_ov = ((wr != 0) && m_cnt == 16) || (m_ov != 0 && clr == 0);
      m_un = ((rd != 0) && m_cnt == 0) || (m_un != 0 && clr == 0);
      m_cnt = m_cnt + int'(we) - int'(re);
      m_wp = (m_wp + int'(we)) % 32;
      m_rp = (m_rp + int'(re)) % 32;
    end
    e.cnt = m_cnt[4:0]; e.wp = m_wp[3:0]; e.rp = m_rp[3:0];
    e.full = m_cnt == 16; e.empty = m_cnt == 0;
    e.af = m_cnt >= m_af; e.ae = m_cnt <= m_ae;
    e.ov = m_ov[0]; e.un = m_un[0];
    if (r == 0 && tl != 0) begin
      m_af = af > 16 ? 16 : af;
      m_ae = ae > 16 ? 16 : ae;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard: queue empty");
    end else begin
      e = q.pop_front();
      a = {count, w_ptr, r_ptr, full, empty, almost_full, almost_empty, overflow, underflow};
      if (a !== e) begin
        failures++;
        $display("FAIL state: got cnt=%0d wp=%0d rp=%0d flags(f,e,af,ae,ov,un)=%b want cnt=%0d wp=%0d rp=%0d flags=%b",
                 a.cnt, a.wp, a.rp, a[5:0], e.cnt, e.wp, e.rp, e[5:0]);
      end
    end
  endtask
  initial begin
    vec_t tbl[25];
    tbl = '{
      '{0,0,0,0,1,0,0,1,   0,0,1,0,1,0,0},
      '{1,0,0,0,0,0,0,9,   9,0,0,0,0,0,0},
      '{1,0,0,0,0,0,0,1,  10,0,0,1,0,0,0},
      '{1,0,0,0,0,0,0,6,  16,1,0,1,0,0,0},
      '{1,0,0,0,0,0,0,1,  16,1,0,1,0,1,0},
      '{0,1,0,0,0,0,0,14,  2,0,0,0,1,1,0},
      '{0,1,0,0,0,0,0,2,   0,0,1,0,1,1,0},
      '{0,1,0,0,0,0,0,1,   0,0,1,0,1,1,1},
      '{0,0,0,1,0,0,0,1,   0,0,1,0,1,0,0},
      '{1,0,0,0,0,0,0,16, 16,1,0,1,0,0,0},
      '{1,1,0,0,0,0,0,1,  15,0,0,1,0,1,0},
      '{0,1,0,1,0,0,0,15,  0,0,1,0,1,0,0},
      '{1,1,0,0,0,0,0,1,   1,0,0,0,1,0,1},
      '{1,0,0,1,0,0,0,4,   5,0,0,0,0,0,0},
      '{1,1,0,0,0,0,0,40,  5,0,0,0,0,0,0},
      '{1,0,0,0,0,0,0,2,   7,0,0,0,0,0,0},
      '{0,0,1,0,0,6,20,1,  7,0,0,0,0,0,0},
      '{0,0,0,0,0,0,0,1,   7,0,0,1,1,0,0},
      '{1,0,0,0,0,0,0,2,   9,0,0,1,1,0,0},
      '{1,0,0,0,1,0,0,1,   0,0,1,0,1,0,0},
      '{1,0,0,0,0,0,0,3,   3,0,0,0,0,0,0},
      '{1,0,0,0,0,0,0,3,   6,0,0,0,0,0,0},
      '{1,0,0,0,0,0,0,4,  10,0,0,1,0,0,0},
      '{0,1,0,0,0,0,0,10,  0,0,1,0,1,0,0},
      '{0,1,0,1,0,0,0,1,   0,0,1,0,1,0,1}
    };
    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < tbl[i].reps; k++)
        step(tbl[i].wr, tbl[i].rd, tbl[i].tl, tbl[i].clr, tbl[i].r, tbl[i].af, tbl[i].ae);
      checks++;
      if ({count, full, empty, almost_full, almost_empty, overflow, underflow} !==
          {tbl[i].cnt[4:0], tbl[i].full[0], tbl[i].empty[0], tbl[i].afl[0], tbl[i].ael[0], tbl[i].ov[0], tbl[i].un[0]}) begin
        failures++;
        $display("FAIL phase%0d: got cnt=%0d flags=%b%b%b%b%b%b want cnt=%0d flags=%0d%0d%0d%0d%0d%0d", i,
                 count, full, empty, almost_full, almost_empty, overflow, underflow,
                 tbl[i].cnt, tbl[i].full, tbl[i].empty, tbl[i].afl, tbl[i].ael, tbl[i].ov, tbl[i].un);
      end
      if (i == 14) begin
        checks++;
        if (4'(w_ptr - r_ptr) !== 4'd5) begin
          failures++;
          $display("FAIL wrap_gap: got w_ptr-r_ptr=%0d want 5", 4'(w_ptr - r_ptr));
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_flag_ctrl.md
# fifo_flag_ctrl

Parametrised pointer and status-flag controller for the team's synchronous FIFO, sitting between the FIFO's request interface and its dual-port storage array. It owns the read/write pointers and occupancy count. It qualifies write and read requests against full/empty and generates registered full, empty, almost-full and almost-empty flags. Thresholds are run-time programmable, and sticky overflow/underflow error flags are provided.

## Interface
Parameters:
- ADDR_W, 4, pointer width; FIFO depth DEPTH = 2**ADDR_W
- AF_DEFAULT, 10, almost-full threshold after reset (count >= threshold asserts)
- AE_DEFAULT, 2, almost-empty threshold after reset (count <= threshold asserts)

Ports:
- clk  in  1  sole clock; all state on rising edge
- rst  in  1  reset; synchronous and active-high
- wr_req  in  1  write request
- rd_req  in  1  read request
- thresh_load  in  1  samples af_thresh/ae_thresh this cycle
- af_thresh  in  ADDR_W+1  new almost-full threshold
- ae_thresh  in  ADDR_W+1  new almost-empty threshold
- err_clr  in  1  clears overflow/underflow
- wr_en  out  1  qualified write strobe to storage (combinational)
- rd_en  out  1  qualified read strobe to storage (combinational)
- w_ptr  out  ADDR_W  storage write address
- r_ptr  out  ADDR_W  storage read address
- count  out  ADDR_W+1  occupancy, 0..DEPTH
- full, empty, almost_full, almost_empty  out  1 each  registered status flags
- overflow, underflow  out  1 each  sticky error flags

## Operation
- Acceptance is decided from the current registered flags.
  - wr_en = wr_req & ~full.
  - rd_en = rd_req & ~empty.
- Pointers are (ADDR_W+1)-bit wrap counters. w_ptr and r_ptr are the low ADDR_W bits; the MSB distinguishes full from empty.
  - Each increments by 1 per accepted op and wraps modulo 2**(ADDR_W+1).
- Count update:
  - count_next = count + wr_en - rd_en.
  - Simultaneous accepted write and read leaves count unchanged; both pointers advance.
- At full with both requests: read accepted, write rejected, overflow set.
- At empty with both requests: write accepted, read rejected, underflow set.
- Flags are computed from count_next and registered, so they always agree with count:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count >= af_reg)
  - almost_empty = (count <= ae_reg)
- Thresholds:
  - thresh_load writes af_reg/ae_reg. Values above DEPTH are clamped to DEPTH.
  - Flags reflect new thresholds from the edge after the load edge.
  - The load and a count change in the same cycle are both honoured; flags use the old thresholds for that edge.
- Errors:
  - overflow sets on wr_req & full; underflow sets on rd_req & empty.
  - Both hold until err_clr or rst. Set wins over err_clr in the same cycle.

## Timing
- Reset values: pointers 0, count 0, empty 1, almost_empty 1 (AE_DEFAULT >= 0), full 0, almost_full 0 (AF_DEFAULT > 0), overflow 0, underflow 0, af_reg = AF_DEFAULT, ae_reg = AE_DEFAULT.
- rst asserted mid-operation: all state returns to reset values at that edge.
  - wr_en/rd_en are forced 0 while rst is high.
  - Any in-flight request is discarded.
- Latency:
  - wr_en/rd_en are combinational from requests, same cycle.
  - count, pointers and all flags update one edge after the accepted op.
- Back-to-back ops are allowed every cycle. Throughput is 1 write + 1 read per cycle.

## Structure
- Package fifo_pkg holds:
  - the fifo_status_t packed struct (full, empty, almost_full, almost_empty, overflow, underflow);
  - localparam helpers DEPTH(ADDR_W) and the threshold clamp function.
- Sub-module fifo_ptr: (ADDR_W+1)-bit wrap counter with synchronous rst and inc, instantiated twice (write, read).
- Flag and threshold logic stays in fifo_flag_ctrl.

## Test plan
- Reset, then 16 writes with no reads (ADDR_W=4):
  - almost_full rises the edge after the 10th write (count=10);
  - full rises after the 16th;
  - 17th wr_req gives wr_en=0, count stays 16, overflow=1.
- From full, 16 reads:
  - almost_empty rises at count=2;
  - empty rises at count=0;
  - extra rd_req sets underflow and leaves r_ptr unchanged.
- At count=16 with wr_req=rd_req=1: rd_en=1, wr_en=0, count=15, overflow=1. At count=0 with both: wr_en=1, count=1, underflow=1.
- Wrap: 40 cycles of simultaneous write and read at count=5:
  - count holds at 5 throughout;
  - w_ptr and r_ptr wrap 15->0 and stay 5 apart modulo 16;
  - no flags change.
- Threshold load af=6, ae=20 at count=7:
  - the next edge gives almost_full=1;
  - ae is clamped to 16, so almost_empty=1.
  - err_clr then clears overflow/underflow.
- rst asserted for one cycle at count=9 with wr_req high: the next edge gives count=0, empty=1, pointers 0, thresholds back to 10/2.
